multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM of the lab3 multi-cycle RV32I core. It sits upstream of the ALU control unit
//  and drives alu_op[1:0] into it: 00 add, 01 branch compare, 10 funct-decoded.
//  It sequences each instruction through IF/ID/EX/MEM/WB and drives all datapath mux, enable and
//  memory strobes. opcode comes from the IR, which only changes in S_IF.
// PARAMETERS
//  none (RV32I opcodes come from opcodes.v)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high; forces S_IF
//  opcode     in   7  IR[6:0]
//  alu_bcond  in   1  branch-taken result from the ALU (valid in S_EX for branches)
//  halt_cond  in   1  x17==10, from the register file read port
//  ir_write   out  1  load IR from memory output
//  i_or_d     out  1  memory address mux: 0 = PC, 1 = ALUOut
//  mem_read   out  1  memory read strobe
//  mem_write  out  1  memory write strobe (sampled on clk edge)
//  alu_src_a  out  1  0 = PC, 1 = register A
//  alu_src_b  out  2  00 = register B, 01 = const 4, 10 = immediate
//  alu_op     out  2  to ALU control unit
//  pc_write   out  1  load PC this edge
//  pc_source  out  1  0 = live ALU result, 1 = ALUOut register
//  reg_write  out  1  register file write enable
//  wb_sel     out  2  00 = ALUOut, 01 = MDR, 10 = live ALU result
//  is_halted  out  1  sticky halt flag
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-high.
//    - While reset=1: state=S_IF and every output is 0.
//    - First S_IF cycle: the first cycle after reset falls.
//  - State register: 4-bit. Outputs decode combinationally from state, opcode and alu_bcond.
//    Any output not listed for a state is 0.
//  - Per-state behaviour:
//    - S_IF: i_or_d=0, mem_read=1, ir_write=1. -> S_ID.
//    - S_ID: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut latches PC+imm.
//      - ECALL with halt_cond=1 -> S_HALT.
//      - ECALL with halt_cond=0, or an unknown opcode -> S_PC4 (treated as nop).
//      - Otherwise -> S_EX.
//    - S_EX, R-type: alu_src_a=1, alu_src_b=00, alu_op=10. -> S_WB_ALU.
//    - S_EX, I-arith: alu_src_a=1, alu_src_b=10, alu_op=10. -> S_WB_ALU.
//      The datapath masks funct7 for I-arith.
//    - S_EX, LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00. -> S_MEM.
//    - S_EX, BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01.
//      - alu_bcond=1: pc_write=1, pc_source=1. -> S_IF.
//      - alu_bcond=0: -> S_PC4.
//    - S_EX, JAL: alu_src_a=0, alu_src_b=01, alu_op=00, reg_write=1, wb_sel=10, pc_write=1,
//      pc_source=1. rd=PC+4 and PC=PC+imm in one edge. -> S_IF.
//    - S_EX, JALR: alu_src_a=1, alu_src_b=10, alu_op=00, so ALUOut=rs1+imm. -> S_JALR2.
//    - S_JALR2: alu_src_a=0, alu_src_b=01, alu_op=00, reg_write=1, wb_sel=10, pc_write=1,
//      pc_source=1. The datapath clears target bit 0. -> S_IF.
//    - S_MEM: i_or_d=1.
//      - LOAD: mem_read=1. -> S_WB_MEM.
//      - STORE: mem_write=1. -> S_PC4.
//    - S_WB_ALU: reg_write=1, wb_sel=00. -> S_PC4.
//    - S_WB_MEM: reg_write=1, wb_sel=01. -> S_PC4.
//    - S_PC4: alu_src_a=0, alu_src_b=01, alu_op=00, pc_write=1, pc_source=0. -> S_IF.
//    - S_HALT: is_halted=1, all strobes 0. Held until reset.
//  - Latency in cycles: R/I 5, LOAD 6, STORE 5, taken branch 3, not-taken branch 4, JAL 3, JALR 4.
//  - Exclusivity: pc_write and reg_write never coexist except in JAL and S_JALR2.
//    mem_read and mem_write are never both 1.
//  - Reset mid-instruction: abandons the sequence at once; no write strobe is asserted.
//  - Unused state encodings: -> S_IF next cycle, with all outputs 0.
// TESTING
//  - reset held 3 cycles, then released, opcode=0110011 -> states IF,ID,EX,WB_ALU,PC4,IF;
//    reg_write=1 only in cycle 4; pc_write=1 only in cycle 5.
//  - opcode=0000011 -> mem_read=1 with i_or_d=1 in cycle 4; reg_write=1 with wb_sel=01 in cycle 5;
//    pc_write in cycle 6.
//  - opcode=1100011, alu_bcond=1 -> pc_write=1, pc_source=1 in cycle 3, then IF.
//    alu_bcond=0 -> cycle 4 pc_write=1, pc_source=0.
//  - opcode=1100111 -> EX then JALR2 with reg_write=1, wb_sel=10, pc_write=1, pc_source=1.
//  - opcode=1110011, halt_cond=1 -> is_halted=1 from cycle 3 onward, all strobes 0.
//    halt_cond=0 -> nop through PC4.
//  - assert reset during S_MEM of a STORE -> mem_write=0 immediately; IF after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core.
// It sequences each instruction through IF/ID/EX/MEM/WB and drives the
// datapath mux selects, enables and memory strobes.
// Ports:
//   clk, reset (async, active-high)
//   opcode, alu_bcond, halt_cond                          : inputs
//   ir_write, i_or_d, mem_read, mem_write, alu_src_a,
//   alu_src_b, alu_op, pc_write, pc_source, reg_write,
//   wb_sel, is_halted                                     : control outputs
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       halt_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       is_halted
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX     = 4'd2,
        S_MEM    = 4'd3,
        S_WB_ALU = 4'd4,
        S_WB_MEM = 4'd5,
        S_PC4    = 4'd6,
        S_JALR2  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_IF;
        ir_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_write  = 1'b0;
        pc_source = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        is_halted = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                // ALUOut latches PC+imm for a possible branch target
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BR, OP_JAL, OP_JALR: state_d = S_EX;
                    OP_ECALL: state_d = halt_cond ? S_HALT : S_PC4;
                    default:  state_d = S_PC4;
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_d   = S_WB_ALU;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = S_WB_ALU;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        if (alu_bcond) begin
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                            state_d   = S_IF;
                        end else begin
                            state_d   = S_PC4;
                        end
                    end
                    OP_JAL: begin
                        // rd <= PC+4 (live ALU) and PC <= ALUOut together
                        alu_src_b = 2'b01;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        state_d   = S_IF;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_JALR2;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_JALR2: begin
                alu_src_b = 2'b01;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_source = 1'b1;
                state_d   = S_IF;
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    state_d   = S_PC4;
                end else begin
                    mem_read  = 1'b1;
                    state_d   = S_WB_MEM;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_PC4;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                state_d   = S_PC4;
            end
            S_PC4: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
                state_d   = S_HALT;
            end
            default: state_d = S_IF;
        endcase

        // Reset kills every strobe at once, not at the next edge
        if (reset) begin
            state_d   = S_IF;
            ir_write  = 1'b0;
            i_or_d    = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_op    = 2'b00;
            pc_write  = 1'b0;
            pc_source = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'b00;
            is_halted = 1'b0;
        end
    end

endmodule
